// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the imem/dmem backing-port arbiter.
// Covers the arbiter FSM states, the captured request record and the word-align helper.
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_MASK_W = ARB_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_I = 3'd1,
    ISSUE_D = 3'd2,
    WAIT_I  = 3'd3,
    WAIT_D  = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_MASK_W-1:0] rmask;
    logic [ARB_MASK_W-1:0] wmask;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic [ARB_ADDR_W-1:0] word_align(input logic [ARB_ADDR_W-1:0] a);
    return {a[ARB_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_capture.sv
// One request capture slot per CPU port, plus its overrun checker.
// pend/pend_req present either the held slot or the request arriving this cycle.
module mem_req_capture
  import mem_port_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  mem_req_t req,
  input  logic     clear,
  output logic     pend,
  output mem_req_t pend_req
);

  logic     valid_r;
  mem_req_t slot_r;
  mem_req_t in_s;
  logic     req_s;

  assign req_s = (req.rmask != '0) || (req.wmask != '0);

  // a read mask suppresses any simultaneous write mask
  always_comb begin
    in_s = req;
    if (req.rmask != '0) begin
      in_s.wmask = '0;
    end else begin
      in_s.wmask = req.wmask;
    end
  end

  // slot frees on clear; a same-edge request refills it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      slot_r  <= '0;
    end else if (req_s && (!valid_r || clear)) begin
      valid_r <= 1'b1;
      slot_r  <= in_s;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign pend     = valid_r || req_s;
  assign pend_req = valid_r ? slot_r : in_s;

  mem_req_capture_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_s),
    .valid (valid_r),
    .clear (clear)
  );

endmodule

// Flags a request presented while the slot is still occupied.
module mem_req_capture_chk (
  input logic clk,
  input logic rst_n,
  input logic req,
  input logic valid,
  input logic clear
);

  a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n) !(req && valid && !clear));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between CPU fetch (imem) and data (dmem) ports.
// One transaction in flight at a time; registered one-cycle resp back to the owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter bit RR_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   imem_addr,
  input  logic [DATA_W/8-1:0] imem_rmask,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_resp,
  output logic                imem_busy,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W/8-1:0] dmem_rmask,
  input  logic [DATA_W/8-1:0] dmem_wmask,
  input  logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_resp,
  output logic                dmem_busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_rmask,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  arb_state_t state_r, state_s;
  mem_req_t   i_in_s, d_in_s, i_req_s, d_req_s, cmd_s, cmd_r;
  logic       i_pend_s, d_pend_s, i_clear_s, d_clear_s;
  logic       grant_d_s, last_d_r, last_d_s;
  logic       i_resp_r, d_resp_r;
  logic [DATA_W-1:0] i_rdata_r, d_rdata_r;

  assign i_in_s = '{addr: imem_addr, rmask: imem_rmask, wmask: '0, wdata: '0};
  assign d_in_s = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};

  mem_req_capture u_icap (.clk(clk), .rst_n(rst_n), .req(i_in_s), .clear(i_clear_s),
                          .pend(i_pend_s), .pend_req(i_req_s));
  mem_req_capture u_dcap (.clk(clk), .rst_n(rst_n), .req(d_in_s), .clear(d_clear_s),
                          .pend(d_pend_s), .pend_req(d_req_s));

  assign i_clear_s = (state_r == WAIT_I) && mem_resp;
  assign d_clear_s = (state_r == WAIT_D) && mem_resp;

  // contention: alternate against the last grant, or dmem priority when RR is off
  always_comb begin
    if (i_pend_s && d_pend_s) begin
      if (RR_EN) begin
        grant_d_s = !last_d_r;
      end else begin
        grant_d_s = 1'b1;
      end
    end else begin
      grant_d_s = d_pend_s;
    end
  end

  // next state and the command to register on leaving IDLE
  always_comb begin
    state_s  = state_r;
    cmd_s    = '0;
    last_d_s = last_d_r;
    case (state_r)
      IDLE: begin
        if (i_pend_s || d_pend_s) begin
          state_s    = grant_d_s ? ISSUE_D : ISSUE_I;
          cmd_s      = grant_d_s ? d_req_s : i_req_s;
          cmd_s.addr = word_align(cmd_s.addr);
          last_d_s   = grant_d_s;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE_I: state_s = WAIT_I;
      ISSUE_D: state_s = WAIT_D;
      WAIT_I: begin
        if (mem_resp) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_I;
        end
      end
      WAIT_D: begin
        if (mem_resp) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_D;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM, grant history and one-cycle command register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      last_d_r <= 1'b1;
      cmd_r    <= '0;
    end else begin
      state_r  <= state_s;
      last_d_r <= last_d_s;
      cmd_r    <= cmd_s;
    end
  end

  // completion pulses; write completions return zero data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_resp_r  <= 1'b0;
      d_resp_r  <= 1'b0;
      i_rdata_r <= '0;
      d_rdata_r <= '0;
    end else begin
      i_resp_r  <= i_clear_s;
      d_resp_r  <= d_clear_s;
      i_rdata_r <= i_clear_s ? mem_rdata : '0;
      d_rdata_r <= (d_clear_s && (d_req_s.wmask == '0)) ? mem_rdata : '0;
    end
  end

  assign imem_busy  = i_pend_s;
  assign dmem_busy  = d_pend_s;
  assign imem_resp  = i_resp_r;
  assign dmem_resp  = d_resp_r;
  assign imem_rdata = i_rdata_r;
  assign dmem_rdata = d_rdata_r;
  assign mem_addr   = cmd_r.addr;
  assign mem_rmask  = cmd_r.rmask;
  assign mem_wmask  = cmd_r.wmask;
  assign mem_wdata  = cmd_r.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and scoreboarded checks of mem_port_arbiter.
// Instance 0 has round-robin enabled, instance 1 uses fixed dmem priority.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] i_addr [2];
  logic [3:0]  i_rmask [2];
  logic [31:0] d_addr [2];
  logic [3:0]  d_rmask [2];
  logic [3:0]  d_wmask [2];
  logic [31:0] d_wdata [2];
  logic [31:0] i_rdata [2];
  logic        i_resp [2];
  logic        i_busy [2];
  logic [31:0] d_rdata [2];
  logic        d_resp [2];
  logic        d_busy [2];
  logic [31:0] m_addr [2];
  logic [3:0]  m_rmask [2];
  logic [3:0]  m_wmask [2];
  logic [31:0] m_wdata [2];

  int lat = 1;
  bit rnd_lat = 1'b0;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mrd = 32'h0;
    logic        mresp = 1'b0;
    logic        pend = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] qaddr = 32'h0;
    int          cnt = 0;
    int          nl = 1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(g == 0 ? 1'b1 : 1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .imem_addr(i_addr[g]), .imem_rmask(i_rmask[g]), .imem_rdata(i_rdata[g]),
      .imem_resp(i_resp[g]), .imem_busy(i_busy[g]),
      .dmem_addr(d_addr[g]), .dmem_rmask(d_rmask[g]), .dmem_wmask(d_wmask[g]),
      .dmem_wdata(d_wdata[g]), .dmem_rdata(d_rdata[g]), .dmem_resp(d_resp[g]),
      .dmem_busy(d_busy[g]),
      .mem_addr(m_addr[g]), .mem_rmask(m_rmask[g]), .mem_wmask(m_wmask[g]),
      .mem_wdata(m_wdata[g]), .mem_rdata(mrd), .mem_resp(mresp)
    );

    // backing memory: not reset, so a stale response can outlive a DUT reset
    always @(posedge clk) begin
      mresp <= 1'b0;
      nl    <= rnd_lat ? int'($urandom_range(1, 20)) : lat;
      if (pend) begin
        if (cnt <= 1) begin
          mresp <= 1'b1;
          mrd   <= wr ? 32'hBAD0_BAD0 : mdata(qaddr);
          pend  <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end else if (m_rmask[g] != 4'h0 || m_wmask[g] != 4'h0) begin
        if (nl == 1) begin
          mresp <= 1'b1;
          mrd   <= (m_rmask[g] == 4'h0) ? 32'hBAD0_BAD0 : mdata(m_addr[g]);
        end else begin
          pend  <= 1'b1;
          cnt   <= nl - 1;
          qaddr <= m_addr[g];
          wr    <= (m_rmask[g] == 4'h0);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input int d);
    i_rmask[d] = 4'h0;
    d_rmask[d] = 4'h0;
    d_wmask[d] = 4'h0;
  endtask

  // simultaneous fetch 0x1004 and sw 0x2000, 1-cycle memory
  task automatic contend(input int d, input bit d_first, input string tag);
    i_addr[d] = 32'h0000_1004; i_rmask[d] = 4'hF;
    d_addr[d] = 32'h0000_2000; d_wmask[d] = 4'hF; d_wdata[d] = 32'hDEAD_BEEF;
    tick(); clr(d);
    chk({tag, "_first_wmask"}, {28'd0, m_wmask[d]}, d_first ? 32'hF : 32'h0);
    tick(); tick();
    chk({tag, "_resp1"}, {30'd0, i_resp[d], d_resp[d]}, d_first ? 32'd1 : 32'd2);
    tick();
    chk({tag, "_second_rmask"}, {28'd0, m_rmask[d]}, d_first ? 32'hF : 32'h0);
    tick(); tick();
    chk({tag, "_resp2"}, {30'd0, i_resp[d], d_resp[d]}, d_first ? 32'd2 : 32'd1);
    chk({tag, "_irdata"}, d_first ? i_rdata[d] : d_rdata[d], d_first ? mdata(32'h1004) : 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    int issued;
    bit saw;

    for (int d = 0; d < 2; d++) begin
      i_addr[d] = 32'h0; d_addr[d] = 32'h0; d_wdata[d] = 32'h0;
      clr(d);
    end
    tick(); tick(); tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", {30'd0, i_busy[d], d_busy[d]}, 32'd0);
      chk("rst_resp", {30'd0, i_resp[d], d_resp[d]}, 32'd0);
      chk("rst_cmd", {24'd0, m_rmask[d], m_wmask[d]}, 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // single fetch, cmd at c1, resp at c3
    i_addr[0] = 32'h0000_1000; i_rmask[0] = 4'hF;
    #1;
    chk("fetch_busy_c0", {31'd0, i_busy[0]}, 32'd1);
    tick(); clr(0);
    chk("fetch_cmd_rmask", {28'd0, m_rmask[0]}, 32'hF);
    chk("fetch_cmd_addr", m_addr[0], 32'h0000_1000);
    tick();
    chk("fetch_cmd_gone", {28'd0, m_rmask[0]}, 32'h0);
    tick();
    chk("fetch_resp", {31'd0, i_resp[0]}, 32'd1);
    chk("fetch_rdata", i_rdata[0], 32'h1000_EFFF);
    chk("fetch_busy_c3", {31'd0, i_busy[0]}, 32'd0);
    tick();
    chk("fetch_resp_once", {31'd0, i_resp[0]}, 32'd0);

    contend(0, 1'b1, "rr_after_i");

    // sb to 0x2003: word-aligned address, byte lane 3, zero rdata
    d_addr[0] = 32'h0000_2003; d_wmask[0] = 4'b1000; d_wdata[0] = 32'hAB00_0000;
    tick(); clr(0);
    chk("sb_wmask", {28'd0, m_wmask[0]}, 32'h8);
    chk("sb_addr", m_addr[0], 32'h0000_2000);
    chk("sb_wdata", m_wdata[0], 32'hAB00_0000);
    tick(); tick();
    chk("sb_resp", {31'd0, d_resp[0]}, 32'd1);
    chk("sb_rdata", d_rdata[0], 32'h0);
    tick();

    contend(0, 1'b0, "rr_after_d");
    for (int k = 0; k < 4; k++) contend(1, 1'b1, "fixed");

    // reset while WAIT_D; the late memory response must be ignored
    lat = 8;
    tick();
    d_addr[0] = 32'h0000_3000; d_rmask[0] = 4'hF;
    tick(); clr(0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, d_busy[0]}, 32'd0);
    chk("rstmid_cmd", {28'd0, m_rmask[0]}, 32'h0);
    tick();
    rst_n = 1'b1;
    lat = 1;
    saw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      saw = saw | d_resp[0] | i_resp[0];
    end
    chk("rstmid_no_resp", {31'd0, saw}, 32'd0);
    chk("rstmid_idle_busy", {31'd0, d_busy[0]}, 32'd0);
    d_addr[0] = 32'h0000_3004; d_rmask[0] = 4'hF;
    tick(); clr(0);
    tick(); tick();
    chk("rstmid_next_resp", {31'd0, d_resp[0]}, 32'd1);
    chk("rstmid_next_rdata", d_rdata[0], mdata(32'h0000_3004));

    // random latency, mixed traffic, per-port in-order scoreboard
    rnd_lat = 1'b1;
    issued = 0;
    tick();
    for (int cyc = 0; cyc < 60000; cyc++) begin
      if (issued >= 1000 && exp_i.size() == 0 && exp_d.size() == 0) break;
      tick();
      clr(0);
      if (i_resp[0] && d_resp[0]) chk("rnd_both_resp", 32'd1, 32'd0);
      if (i_resp[0]) begin
        if (exp_i.size() == 0) chk("rnd_i_extra", i_rdata[0], 32'hFFFF_FFFF);
        else chk("rnd_i_data", i_rdata[0], exp_i.pop_front());
      end
      if (d_resp[0]) begin
        if (exp_d.size() == 0) chk("rnd_d_extra", d_rdata[0], 32'hFFFF_FFFF);
        else chk("rnd_d_data", d_rdata[0], exp_d.pop_front());
      end
      if (issued < 1000 && !i_busy[0] && $urandom_range(0, 2) == 0) begin
        a = $urandom & 32'h0000_FFFC;
        i_addr[0] = a; i_rmask[0] = 4'hF;
        exp_i.push_back(mdata(a));
        issued++;
      end
      if (issued < 1000 && !d_busy[0] && $urandom_range(0, 2) == 0) begin
        a = $urandom & 32'h0000_FFFC;
        d_addr[0] = a;
        if ($urandom_range(0, 1) == 0) begin
          d_rmask[0] = 4'hF;
          exp_d.push_back(mdata(a));
        end else begin
          d_wmask[0] = 4'($urandom_range(1, 15));
          d_wdata[0] = $urandom;
          exp_d.push_back(32'h0);
        end
        issued++;
      end
    end
    chk("rnd_issued", issued, 32'd1000);
    chk("rnd_lost", exp_i.size() + exp_d.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
